// File: rtl/data_memory_responder.sv
// Single-port 64-bit data memory with a valid/ready request/response interface.
// Serves RV64I loads and stores after a fixed LATENCY and reports illegal accesses.
module data_memory_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_error
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q;
  logic [63:0] addr_q, wdata_q;
  logic [2:0]  funct3_q;
  logic [63:0] rdata_q, rdata_d;
  logic        error_q, error_d;
  logic [63:0] mem_q [DEPTH_WORDS];

  logic             latch_req, do_access;
  logic             acc_write;
  logic [63:0]      acc_addr, acc_wdata;
  logic [2:0]       acc_funct3;
  logic             acc_oob, acc_misaligned, acc_illegal, acc_err;
  logic [IDX_W-1:0] acc_idx;
  logic [63:0]      acc_word, acc_shifted, load_val, store_data;
  logic [7:0]       size_mask, byte_en;

  // An access from IDLE only happens with LATENCY=0 and must use the live request.
  assign acc_write  = (state_q == IDLE) ? req_write  : write_q;
  assign acc_addr   = (state_q == IDLE) ? req_addr   : addr_q;
  assign acc_funct3 = (state_q == IDLE) ? req_funct3 : funct3_q;
  assign acc_wdata  = (state_q == IDLE) ? req_wdata  : wdata_q;

  always_comb begin
    acc_idx = acc_addr[IDX_W+2:3];
    acc_oob = (acc_addr[63:3] >= 61'(DEPTH_WORDS));
    case (acc_funct3[1:0])
      2'd0:    begin size_mask = 8'h01; acc_misaligned = 1'b0;            end
      2'd1:    begin size_mask = 8'h03; acc_misaligned = acc_addr[0];     end
      2'd2:    begin size_mask = 8'h0F; acc_misaligned = |acc_addr[1:0];  end
      default: begin size_mask = 8'hFF; acc_misaligned = |acc_addr[2:0];  end
    endcase
    acc_illegal = acc_write ? acc_funct3[2] : (acc_funct3 == 3'b111);
    acc_err     = acc_illegal || acc_misaligned || acc_oob;

    acc_word    = acc_oob ? 64'd0 : mem_q[acc_idx];
    acc_shifted = acc_word >> {acc_addr[2:0], 3'b000};
    case (acc_funct3)
      3'b000:  load_val = {{56{acc_shifted[7]}},  acc_shifted[7:0]};
      3'b001:  load_val = {{48{acc_shifted[15]}}, acc_shifted[15:0]};
      3'b010:  load_val = {{32{acc_shifted[31]}}, acc_shifted[31:0]};
      3'b100:  load_val = {56'd0, acc_shifted[7:0]};
      3'b101:  load_val = {48'd0, acc_shifted[15:0]};
      3'b110:  load_val = {32'd0, acc_shifted[31:0]};
      default: load_val = acc_shifted;
    endcase

    byte_en    = size_mask << acc_addr[2:0];
    store_data = acc_wdata << {acc_addr[2:0], 3'b000};
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    latch_req = 1'b0;
    do_access = 1'b0;
    rdata_d   = rdata_q;
    error_d   = error_q;
    case (state_q)
      IDLE: if (req_valid) begin
        latch_req = 1'b1;
        if (LATENCY == 0) begin
          do_access = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d   = 4'(LATENCY);
          state_d = WAIT;
        end
      end
      WAIT: if (cnt_q == 4'd0) begin
        do_access = 1'b1;
        state_d   = RESP;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (do_access) begin
      error_d = acc_err;
      rdata_d = (acc_err || acc_write) ? 64'd0 : load_val;
    end
  end

  // NOTE: the storage array is reset word by word because reset must clear memory contents,
  // which rules out a RAM macro; all state uses non-blocking assignments.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      write_q  <= 1'b0;
      addr_q   <= 64'd0;
      funct3_q <= 3'd0;
      wdata_q  <= 64'd0;
      rdata_q  <= 64'd0;
      error_q  <= 1'b0;
      for (int i = 0; i < int'(DEPTH_WORDS); i++) mem_q[i] <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
      if (latch_req) begin
        write_q  <= req_write;
        addr_q   <= req_addr;
        funct3_q <= req_funct3;
        wdata_q  <= req_wdata;
      end
      if (do_access && acc_write && !acc_err) begin
        for (int b = 0; b < 8; b++)
          if (byte_en[b]) mem_q[acc_idx][8*b +: 8] <= store_data[8*b +: 8];
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_error = error_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed self-checking bench for data_memory_responder (DEPTH_WORDS=64, LATENCY=2).
module tb_data_memory_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [63:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid, resp_ready, resp_error;
  logic [63:0] resp_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  data_memory_responder dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_funct3 (req_funct3),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input logic w, input logic [63:0] a, input logic [2:0] f3,
                           input logic [63:0] wd);
    req_valid  = 1'b1;
    req_write  = w;
    req_addr   = a;
    req_funct3 = f3;
    req_wdata  = wd;
  endtask

  // Called at a falling edge; returns at a falling edge with the response consumed.
  task automatic txn(input string tag, input logic w, input logic [63:0] a, input logic [2:0] f3,
                     input logic [63:0] wd, input logic [63:0] exp_rd, input logic exp_er);
    int lat;
    drive_req(w, a, f3, wd);
    check({tag, "_ready"}, 64'(req_ready), 64'd1);
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    req_valid = 1'b0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, "_latency"}, 64'(lat), 64'd3);
    check({tag, "_rdata"}, resp_rdata, exp_rd);
    check({tag, "_error"}, 64'(resp_error), 64'(exp_er));
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] held;
    int          wait_cnt;

    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_funct3 = '0; req_wdata = '0;
    resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready",  64'(req_ready),  64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_rdata",      resp_rdata,      64'd0);
    check("rst_error",      64'(resp_error), 64'd0);
    reset = 1'b0;

    // First request goes out right away, so it is accepted at the first edge after reset.
    txn("sd10",   1'b1, 64'h10,  3'b011, 64'h8877665544332211, 64'd0, 1'b0);
    txn("ld10",   1'b0, 64'h10,  3'b011, 64'd0, 64'h8877665544332211, 1'b0);
    txn("lb17",   1'b0, 64'h17,  3'b000, 64'd0, 64'hFFFFFFFFFFFFFF88, 1'b0);
    txn("lbu17",  1'b0, 64'h17,  3'b100, 64'd0, 64'h0000000000000088, 1'b0);
    txn("lh12",   1'b0, 64'h12,  3'b001, 64'd0, 64'h0000000000004433, 1'b0);
    txn("lwu14",  1'b0, 64'h14,  3'b110, 64'd0, 64'h0000000088776655, 1'b0);
    txn("lw14",   1'b0, 64'h14,  3'b010, 64'd0, 64'hFFFFFFFF88776655, 1'b0);
    txn("lhu16",  1'b0, 64'h16,  3'b101, 64'd0, 64'h0000000000008877, 1'b0);
    txn("sh13",   1'b1, 64'h13,  3'b001, 64'hFFFF, 64'd0, 1'b1);
    txn("ld10b",  1'b0, 64'h10,  3'b011, 64'd0, 64'h8877665544332211, 1'b0);
    txn("ld200",  1'b0, 64'h200, 3'b011, 64'd0, 64'd0, 1'b1);
    txn("ld1f8",  1'b0, 64'h1F8, 3'b011, 64'd0, 64'd0, 1'b0);
    txn("lf3_7",  1'b0, 64'h10,  3'b111, 64'd0, 64'd0, 1'b1);
    txn("sf3_4",  1'b1, 64'h10,  3'b100, 64'h0, 64'd0, 1'b1);
    txn("sb11",   1'b1, 64'h11,  3'b000, 64'hAB, 64'd0, 1'b0);
    txn("ld10c",  1'b0, 64'h10,  3'b011, 64'd0, 64'h887766554433AB11, 1'b0);
    txn("sw18",   1'b1, 64'h18,  3'b010, 64'hDEADBEEFCAFEF00D, 64'd0, 1'b0);
    txn("ld18",   1'b0, 64'h18,  3'b011, 64'd0, 64'h00000000CAFEF00D, 1'b0);

    // Response held off for 5 cycles while a stray store request is presented.
    drive_req(1'b0, 64'h10, 3'b011, 64'd0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    wait_cnt = 0;
    while (!resp_valid && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
      @(negedge clk);
    end
    check("hold_latency", 64'(wait_cnt), 64'd3);
    held = resp_rdata;
    check("hold_rdata", held, 64'h887766554433AB11);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) drive_req(1'b1, 64'h10, 3'b011, 64'd0);
      if (i == 3) req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("hold_valid_%0d", i), 64'(resp_valid), 64'd1);
      check($sformatf("hold_stable_%0d", i), resp_rdata, held);
      check($sformatf("hold_ready_%0d", i), 64'(req_ready), 64'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check("hold_release_valid", 64'(resp_valid), 64'd0);
    check("hold_release_ready", 64'(req_ready),  64'd1);
    txn("ld10d", 1'b0, 64'h10, 3'b011, 64'd0, 64'h887766554433AB11, 1'b0);

    // Reset during WAIT of an accepted store aborts it and clears storage.
    drive_req(1'b1, 64'h20, 3'b010, 64'h12345678);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("arst_req_ready",  64'(req_ready),  64'd1);
    check("arst_resp_valid", 64'(resp_valid), 64'd0);
    check("arst_rdata",      resp_rdata,      64'd0);
    check("arst_error",      64'(resp_error), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    txn("lw20",  1'b0, 64'h20, 3'b010, 64'd0, 64'd0, 1'b0);
    txn("ld10e", 1'b0, 64'h10, 3'b011, 64'd0, 64'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
